// File: rtl/pipelined_mult_q_if.sv
// Handshake and data bundle for pipelined_mult_q: operand input side, result output side,
// and the sticky overflow flag with its clear.
interface pipelined_mult_q_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  a;
    logic signed [IN_W-1:0]  b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] res;
    logic                    ovf;
    logic                    ovf_sticky;
    logic                    clr_ovf;

    modport master (
        output in_valid, a, b, out_ready, clr_ovf,
        input  in_ready, out_valid, res, ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, a, b, out_ready, clr_ovf,
        output in_ready, out_valid, res, ovf, ovf_sticky
    );
endinterface

// File: rtl/pipelined_mult_q.sv
// Pipelined signed fixed-point multiplier: full product, round-half-up then arithmetic shift,
// range check with per-sample and sticky overflow. Define MULT_SAT_EN to clamp instead of wrap.
module pipelined_mult_q #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_mult_q_if.slave bus
);
    localparam int PW = 2 * IN_W;
    localparam logic signed [PW:0] RND =
        (SHIFT > 0) ? ((PW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    function automatic logic signed [PW:0] scale_q(input logic signed [PW-1:0] p);
        logic signed [PW:0] ext;
        ext = {p[PW-1], p};
        return (ext + RND) >>> SHIFT;
    endfunction

    // In range exactly when every bit from the output sign bit upward agrees.
    function automatic logic ovf_chk(input logic signed [PW:0] q);
        return !((&q[PW:OUT_W-1]) || !(|q[PW:OUT_W-1]));
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_res(input logic signed [PW:0] q);
`ifdef MULT_SAT_EN
        if (ovf_chk(q))
            return q[PW] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        else
            return q[OUT_W-1:0];
`else
        return q[OUT_W-1:0];
`endif
    endfunction

    logic [STAGES:1]         r_vld;
    logic [STAGES:1]         w_ld;
    logic signed [IN_W-1:0]  r_a_p1;
    logic signed [IN_W-1:0]  r_b_p1;
    logic signed [PW-1:0]    w_prod_p1;
    logic signed [PW-1:0]    w_fin;
    logic signed [PW:0]      w_q;
    logic signed [OUT_W-1:0] r_res;
    logic                    r_ovf;
    logic                    r_ovf_sticky;

    // A stage advances when it or any stage downstream of it holds a bubble, or the output drains.
    always_comb begin
        w_ld = '0;
        for (int k = 1; k <= STAGES; k++) begin
            w_ld[k] = bus.out_ready;
            for (int j = k; j <= STAGES; j++)
                if (!r_vld[j]) w_ld[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_ld[1]) r_vld[1] <= bus.in_valid;
            for (int k = 2; k <= STAGES; k++)
                if (w_ld[k]) r_vld[k] <= r_vld[k-1];
        end
    end

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (w_ld[1] && bus.in_valid) begin
            r_a_p1 <= bus.a;
            r_b_p1 <= bus.b;
        end
    end

    assign w_prod_p1 = PW'(r_a_p1) * PW'(r_b_p1);

    // Stage 2..STAGES-1: full product and plain delay
    generate
        if (STAGES > 2) begin : g_dly
            logic signed [PW-1:0] r_prod_p [2:STAGES-1];
            always_ff @(posedge clk) begin
                if (w_ld[2] && r_vld[1]) r_prod_p[2] <= w_prod_p1;
                for (int k = 3; k < STAGES; k++)
                    if (w_ld[k] && r_vld[k-1]) r_prod_p[k] <= r_prod_p[k-1];
            end
            assign w_fin = r_prod_p[STAGES-1];
        end else begin : g_nodly
            assign w_fin = w_prod_p1;
        end
    endgenerate

    assign w_q = scale_q(w_fin);

    // Final stage: scaled result and overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
            r_ovf <= 1'b0;
        end else if (w_ld[STAGES] && r_vld[STAGES-1]) begin
            r_res <= sat_res(w_q);
            r_ovf <= ovf_chk(w_q);
        end
    end

    // A setting transfer outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf_sticky <= 1'b0;
        else if (r_vld[STAGES] && bus.out_ready && r_ovf)
            r_ovf_sticky <= 1'b1;
        else if (bus.clr_ovf)
            r_ovf_sticky <= 1'b0;
    end

    assign bus.in_ready   = w_ld[1];
    assign bus.out_valid  = r_vld[STAGES];
    assign bus.res        = r_res;
    assign bus.ovf        = r_ovf;
    assign bus.ovf_sticky = r_ovf_sticky;
endmodule

// File: tb/tb_pipelined_mult_q.sv
// Directed and randomized bench for pipelined_mult_q (Q15 x Q15 -> Q15) at depths 3, 2 and 5.
module tb_pipelined_mult_q;
    logic clk;
    logic rst;
    logic rst_r;
    int   n_vec;
    int   n_err;

`ifdef MULT_SAT_EN
    localparam logic [15:0] OVF_RES = 16'h7FFF;
`else
    localparam logic [15:0] OVF_RES = 16'h8000;
`endif

    localparam int NV = 8;
    logic [15:0] tv_a [NV] = '{16'h4000, 16'h0001, 16'h0001, 16'hFFFF,
                               16'hFFFD, 16'h8000, 16'h7FFF, 16'h8000};
    logic [15:0] tv_b [NV] = '{16'h4000, 16'h4000, 16'h3FFF, 16'h4000,
                               16'h4000, 16'h7FFF, 16'h7FFF, 16'h8000};
    logic [16:0] tv_e [NV] = '{17'h02000, 17'h00001, 17'h00000, 17'h00000,
                               17'h0FFFF, 17'h08001, 17'h07FFE, {1'b1, OVF_RES}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_r = 1'b1;
        #22 rst_r = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic signed [15:0] a, input logic signed [15:0] b);
        longint      p;
        longint      q;
        logic [15:0] r;
        logic        o;
        p = longint'(a) * longint'(b);
        q = (p + longint'(16384)) >>> 15;
        o = (q > 32767) || (q < -32768);
        r = q[15:0];
`ifdef MULT_SAT_EN
        if (o) r = (q > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {o, r};
    endfunction

    pipelined_mult_q_if #(.IN_W(16), .OUT_W(16)) m_if ();

    pipelined_mult_q #(.IN_W(16), .OUT_W(16), .SHIFT(15), .STAGES(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int ST = (g == 0) ? 2 : 5;
        bit done = 1'b0;

        pipelined_mult_q_if #(.IN_W(16), .OUT_W(16)) r_if ();

        pipelined_mult_q #(.IN_W(16), .OUT_W(16), .SHIFT(15), .STAGES(ST)) u_rdut (
            .clk (clk),
            .rst (rst_r),
            .bus (r_if)
        );

        initial begin
            logic [16:0] exp_q [$];
            int acc;
            int cyc;
            acc = 0;
            cyc = 0;
            r_if.in_valid  = 1'b0;
            r_if.a         = '0;
            r_if.b         = '0;
            r_if.out_ready = 1'b0;
            r_if.clr_ovf   = 1'b0;
            wait (!rst_r);
            while ((acc < 1000 || exp_q.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                r_if.in_valid  = (acc < 1000) && ($urandom_range(3) != 0);
                r_if.a         = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
                r_if.b         = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
                r_if.out_ready = ($urandom_range(3) != 0);
                #1;
                if (r_if.in_valid && r_if.in_ready) begin
                    exp_q.push_back(model(r_if.a, r_if.b));
                    acc++;
                end
                if (r_if.out_valid && r_if.out_ready) begin
                    if (exp_q.size() == 0)
                        chk($sformatf("rnd%0d_extra", ST), {r_if.ovf, r_if.res}, 32'hDEAD);
                    else
                        chk($sformatf("rnd%0d", ST), {r_if.ovf, r_if.res}, exp_q.pop_front());
                end
            end
            r_if.in_valid = 1'b0;
            chk($sformatf("rnd%0d_acc", ST), acc, 1000);
            chk($sformatf("rnd%0d_left", ST), exp_q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        int          idx_in;
        int          idx_out;
        int          w;
        int          n_in;
        int          n_out;
        int          stray;
        logic [15:0] prev_res;
        logic        prev_stall;

        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        m_if.in_valid  = 1'b0;
        m_if.a         = '0;
        m_if.b         = '0;
        m_if.out_ready = 1'b0;
        m_if.clr_ovf   = 1'b0;

        #12;
        chk("rst_out_valid", m_if.out_valid, 0);
        chk("rst_res", $unsigned(m_if.res), 0);
        chk("rst_ovf", m_if.ovf, 0);
        chk("rst_sticky", m_if.ovf_sticky, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", m_if.in_ready, 1);

        // latency of a single accepted sample
        @(negedge clk);
        m_if.in_valid  = 1'b1;
        m_if.a         = 16'h4000;
        m_if.b         = 16'h4000;
        m_if.out_ready = 1'b1;
        #1 chk("lat_accept", m_if.in_ready, 1);
        @(negedge clk);
        m_if.in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1 chk($sformatf("lat_vld_c%0d", i), m_if.out_valid, (i == 3));
            if (i < 3) @(negedge clk);
        end
        chk("lat_res", {m_if.ovf, m_if.res}, 17'h02000);

        // back-to-back table of rounding and overflow vectors
        @(negedge clk);
        idx_in  = 0;
        idx_out = 0;
        for (int c = 0; c < 40 && idx_out < NV; c++) begin
            m_if.in_valid = (idx_in < NV);
            if (idx_in < NV) begin
                m_if.a = tv_a[idx_in];
                m_if.b = tv_b[idx_in];
            end
            #1;
            if (m_if.in_valid && m_if.in_ready) idx_in++;
            if (m_if.out_valid && m_if.out_ready) begin
                chk($sformatf("vec%0d", idx_out), {m_if.ovf, m_if.res}, tv_e[idx_out]);
                idx_out++;
            end
            @(negedge clk);
        end
        m_if.in_valid = 1'b0;
        chk("vec_count", idx_out, NV);
        #1 chk("sticky_set", m_if.ovf_sticky, 1);
        m_if.clr_ovf = 1'b1;
        @(negedge clk);
        m_if.clr_ovf = 1'b0;
        #1 chk("sticky_clr", m_if.ovf_sticky, 0);

        // overflow transfer in the same cycle as a clear
        m_if.out_ready = 1'b0;
        @(negedge clk);
        m_if.in_valid = 1'b1;
        m_if.a        = 16'h8000;
        m_if.b        = 16'h8000;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (!m_if.out_valid && w < 10);
        chk("setwins_vld", m_if.out_valid, 1);
        chk("setwins_res", {m_if.ovf, m_if.res}, {1'b1, OVF_RES});
        m_if.clr_ovf   = 1'b1;
        m_if.out_ready = 1'b1;
        @(negedge clk);
        m_if.clr_ovf = 1'b0;
        #1 chk("setwins_sticky", m_if.ovf_sticky, 1);
        m_if.clr_ovf = 1'b1;
        @(negedge clk);
        m_if.clr_ovf = 1'b0;

        // backpressure: 10 samples, output stalled for cycles 4..9
        n_in       = 0;
        n_out      = 0;
        prev_stall = 1'b0;
        prev_res   = '0;
        for (int c = 0; c < 60 && n_out < 10; c++) begin
            @(negedge clk);
            m_if.in_valid  = (n_in < 10);
            m_if.a         = 16'((n_in + 1) * 256);
            m_if.b         = 16'h4000;
            m_if.out_ready = !(c >= 4 && c <= 9);
            #1;
            if (prev_stall) chk("bp_hold", $unsigned(m_if.res), prev_res);
            if (c >= 5 && c <= 9) chk("bp_in_ready", m_if.in_ready, 0);
            if (m_if.in_valid && m_if.in_ready) n_in++;
            if (m_if.out_valid && m_if.out_ready) begin
                chk($sformatf("bp_order%0d", n_out), $unsigned(m_if.res), 16'((n_out + 1) * 128));
                n_out++;
            end
            prev_stall = m_if.out_valid && !m_if.out_ready;
            prev_res   = m_if.res;
        end
        m_if.in_valid = 1'b0;
        chk("bp_count", n_out, 10);

        // asynchronous reset with two samples in flight
        @(negedge clk);
        m_if.out_ready = 1'b0;
        m_if.in_valid  = 1'b1;
        m_if.a         = 16'h4000;
        m_if.b         = 16'h4000;
        @(negedge clk);
        m_if.a = 16'h2000;
        @(negedge clk);
        m_if.in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("prerst_vld", m_if.out_valid, 1);
        chk("prerst_res", $unsigned(m_if.res), 16'h2000);
        #2 rst = 1'b1;
        #1;
        chk("midrst_vld", m_if.out_valid, 0);
        chk("midrst_res", $unsigned(m_if.res), 0);
        @(negedge clk);
        rst = 1'b0;
        m_if.out_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (m_if.out_valid) stray++;
        end
        chk("postrst_stray", stray, 0);
        chk("postrst_in_ready", m_if.in_ready, 1);

        for (int i = 0; i < 40000 && !(g_rnd[0].done && g_rnd[1].done); i++)
            @(negedge clk);
        chk("rnd_done", {g_rnd[0].done, g_rnd[1].done}, 2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
